// File: rtl/controller_serializer_pkg.sv
// ---------------------------------------------------------------------------
// controller_serializer_pkg
// Shared definitions for the console controller serializer: FSM state
// encoding, default timing/frame parameters, the presence-bit constant and
// the helper that assembles the outgoing frame word.
// ---------------------------------------------------------------------------
package controller_serializer_pkg;

  localparam int   DEBOUNCE_CYCLES_DEFAULT = 250000;  // 10 ms at 25 MHz
  localparam int   FRAME_BITS_DEFAULT      = 8;       // 7 buttons + presence
  localparam int   BTN_COUNT               = 7;
  localparam logic PRESENCE_BIT            = 1'b1;

  // Explicit codes keep the encoding stable for legacy tooling.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Frame word: presence bit on top, button 0 in the LSB (sent first).
  function automatic logic [BTN_COUNT:0] frame_word(input logic [BTN_COUNT-1:0] btns);
    return {PRESENCE_BIT, btns};
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// ---------------------------------------------------------------------------
// btn_debouncer
// Single-bit debouncer. The accepted level only follows the (already
// synchronized) sample after DEBOUNCE_CYCLES consecutive samples that all
// disagree with it; any agreeing sample restarts the count.
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   sample   - synchronized raw button level
//   level    - registered debounced level
// ---------------------------------------------------------------------------
module btn_debouncer
  import controller_serializer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample,
  output logic level
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // The sample that makes the run DEBOUNCE_CYCLES long is seen while the
  // counter still holds DEBOUNCE_CYCLES-1, so the counter never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             level_r;

  assign level = level_r;

  // Count disagreeing samples and accept the new level once the run is long enough
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else if (sample == level_r) begin
      cnt_r   <= '0;
    end else if (cnt_r == CNT_LAST) begin
      level_r <= sample;
      cnt_r   <= '0;
    end else begin
      cnt_r   <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/controller_serializer.sv
// ---------------------------------------------------------------------------
// controller_serializer
// Debounces seven button inputs and serializes them to a game console using
// the console's latch/shift-clock protocol. The frame is {presence, buttons}
// shifted LSB first.
// Ports:
//   clk_25mhz   - sole system clock, rising edge
//   reset_n     - asynchronous active-low reset
//   btn[6:0]    - raw active-high button levels (asynchronous)
//   ctrl_latch  - console latch strobe (asynchronous), high = capture
//   ctrl_clk    - console shift clock (asynchronous), rising edge = next bit
//   ctrl_data   - registered serial data to the console
//   btn_state   - registered debounced button levels
//   frame_done  - one-cycle pulse when the last frame bit has been shifted
// ---------------------------------------------------------------------------
module controller_serializer
  import controller_serializer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int FRAME_BITS      = FRAME_BITS_DEFAULT
) (
  input  logic                 clk_25mhz,
  input  logic                 reset_n,
  input  logic [BTN_COUNT-1:0] btn,
  input  logic                 ctrl_latch,
  input  logic                 ctrl_clk,
  output logic                 ctrl_data,
  output logic [BTN_COUNT-1:0] btn_state,
  output logic                 frame_done
);

  localparam int                   BIT_CNT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = BIT_CNT_W'(FRAME_BITS);

  // Synchronizers
  logic [BTN_COUNT-1:0] btn_meta_r;
  logic [BTN_COUNT-1:0] btn_sync_r;
  logic                 latch_meta_r;
  logic                 latch_sync_r;
  logic                 clk_meta_r;
  logic                 clk_sync_r;
  logic                 clk_prev_r;
  logic                 clk_rise_s;

  // Debounced buttons and frame word
  logic [BTN_COUNT-1:0]  btn_state_s;
  logic [FRAME_BITS-1:0] frame_s;

  // FSM and shifter
  state_e                state_r;
  state_e                state_nxt_s;
  logic [FRAME_BITS-1:0] shreg_r;
  logic [FRAME_BITS-1:0] shreg_nxt_s;
  logic [FRAME_BITS-1:0] shifted_s;
  logic [BIT_CNT_W-1:0]  bit_cnt_r;
  logic [BIT_CNT_W-1:0]  bit_cnt_nxt_s;
  logic [BIT_CNT_W-1:0]  bit_cnt_inc_s;
  logic                  ctrl_data_r;
  logic                  data_nxt_s;
  logic                  frame_done_r;
  logic                  done_nxt_s;

  // Two-flop synchronizers for every asynchronous input, plus edge history
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta_r   <= '0;
      btn_sync_r   <= '0;
      latch_meta_r <= 1'b0;
      latch_sync_r <= 1'b0;
      clk_meta_r   <= 1'b0;
      clk_sync_r   <= 1'b0;
      clk_prev_r   <= 1'b0;
    end else begin
      btn_meta_r   <= btn;
      btn_sync_r   <= btn_meta_r;
      latch_meta_r <= ctrl_latch;
      latch_sync_r <= latch_meta_r;
      clk_meta_r   <= ctrl_clk;
      clk_sync_r   <= clk_meta_r;
      clk_prev_r   <= clk_sync_r;
    end
  end

  // Edge is detected on the synchronized value itself so ctrl_data
  // updates on the third system edge after the pin changes.
  assign clk_rise_s = clk_sync_r & ~clk_prev_r;

  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_deb
    btn_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk_25mhz),
      .reset_n (reset_n),
      .sample  (btn_sync_r[i]),
      .level   (btn_state_s[i])
    );
  end

  assign frame_s       = FRAME_BITS'(frame_word(btn_state_s));
  assign shifted_s     = {1'b0, shreg_r[FRAME_BITS-1:1]};
  assign bit_cnt_inc_s = bit_cnt_r + BIT_CNT_W'(1);

  // Next-state logic: latch high overrides everything, including a coincident shift edge
  always_comb begin
    state_nxt_s   = state_r;
    shreg_nxt_s   = shreg_r;
    bit_cnt_nxt_s = bit_cnt_r;
    data_nxt_s    = 1'b0;
    done_nxt_s    = 1'b0;
    if (latch_sync_r) begin
      state_nxt_s   = ST_LOAD;
      shreg_nxt_s   = frame_s;
      bit_cnt_nxt_s = '0;
      data_nxt_s    = frame_s[0];
    end else begin
      case (state_r)
        ST_IDLE: begin
          data_nxt_s = 1'b0;
        end
        ST_LOAD: begin
          // Latch has fallen: last reload, then start shifting.
          state_nxt_s   = ST_SHIFT;
          shreg_nxt_s   = frame_s;
          bit_cnt_nxt_s = '0;
          data_nxt_s    = frame_s[0];
        end
        ST_SHIFT: begin
          if (clk_rise_s) begin
            shreg_nxt_s   = shifted_s;
            bit_cnt_nxt_s = bit_cnt_inc_s;
            if (bit_cnt_inc_s == BIT_CNT_LAST) begin
              state_nxt_s = ST_DONE;
              done_nxt_s  = 1'b1;
              data_nxt_s  = 1'b0;
            end else begin
              data_nxt_s  = shifted_s[0];
            end
          end else begin
            data_nxt_s = shreg_r[0];
          end
        end
        ST_DONE: begin
          data_nxt_s = 1'b0;
        end
        default: begin
          state_nxt_s   = ST_IDLE;
          shreg_nxt_s   = '0;
          bit_cnt_nxt_s = '0;
        end
      endcase
    end
  end

  // FSM, shifter and registered outputs
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      shreg_r      <= '0;
      bit_cnt_r    <= '0;
      ctrl_data_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      shreg_r      <= shreg_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      ctrl_data_r  <= data_nxt_s;
      frame_done_r <= done_nxt_s;
    end
  end

  assign ctrl_data  = ctrl_data_r;
  assign btn_state  = btn_state_s;
  assign frame_done = frame_done_r;

endmodule

// File: doc/controller_serializer.md
CONTROLLER_SERIALIZER -- requirements
Module: controller_serializer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, stable-sample count before a button change is accepted (10 ms at 25 MHz).
REQ-002 Parameter FRAME_BITS, default 8, bits shifted per frame (7 buttons + 1 presence bit).
REQ-003 clk_25mhz  input  1  sole clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 btn  input  7  raw button levels, active-high, asynchronous.
REQ-006 ctrl_latch  input  1  console latch strobe, asynchronous; high = capture buttons.
REQ-007 ctrl_clk  input  1  console shift clock, asynchronous; rising edge = advance one bit.
REQ-008 ctrl_data  output  1  registered serial data to console, active-high.
REQ-009 btn_state  output  7  registered debounced button levels.
REQ-010 frame_done  output  1  one-cycle pulse when the last frame bit has been shifted out.

Function
REQ-011 btn, ctrl_latch and ctrl_clk each SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Each btn bit SHALL debounce independently: btn_state[i] takes the synchronized value only after DEBOUNCE_CYCLES consecutive identical samples differing from btn_state[i]; any mismatch restarts that bit's counter.
REQ-013 Frame word SHALL be {1'b1, btn_state[6:0]}, transmitted LSB first (btn_state[0] first, presence bit last).
REQ-014 FSM states SHALL be IDLE, LOAD, SHIFT, DONE.
REQ-015 IDLE: ctrl_data = 0; synchronized ctrl_latch high -> LOAD.
REQ-016 LOAD: shift register reloads from the frame word every cycle, ctrl_data = frame bit 0, bit counter = 0; synchronized latch falling -> SHIFT.
REQ-017 SHIFT: each synchronized ctrl_clk rising edge shifts right by one (zero fill), counter += 1, ctrl_data = new bit 0; the edge taking counter to FRAME_BITS -> DONE with frame_done pulsed in that cycle and ctrl_data = 0.
REQ-018 DONE: ctrl_data = 0, further ctrl_clk edges ignored; latch high -> LOAD.
REQ-019 Latch high in any state SHALL force LOAD; a ctrl_clk edge in the same cycle as latch high SHALL be ignored.
REQ-020 A ctrl_clk edge while latch high or in IDLE SHALL have no effect.
REQ-021 Latency: a pin edge on ctrl_latch/ctrl_clk SHALL be reflected on ctrl_data at the 3rd clk_25mhz rising edge, counting the first edge that samples it.
REQ-022 Console clock SHALL be supported when each ctrl_clk high and low phase lasts at least 3 clk_25mhz cycles; shorter phases are unsupported.
REQ-023 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); bit counter width $clog2(FRAME_BITS+1); no wrap in either.
REQ-024 btn_state changes during SHIFT SHALL NOT alter the frame in flight.

Reset
REQ-025 reset_n low SHALL immediately force: state IDLE, ctrl_data 0, btn_state 0, frame_done 0, shift register 0, all counters 0, synchronizer flops 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; after release the block waits for a new latch.
REQ-027 Reset release SHALL need no synchronization beyond the release being synchronous to clk_25mhz at board level.

Structure
REQ-028 Shared package SHALL hold the FSM state enum, default DEBOUNCE_CYCLES, FRAME_BITS and the presence-bit constant.
REQ-029 One sub-module, btn_debouncer (single bit, parameter DEBOUNCE_CYCLES, instantiated 7 times), SHALL implement REQ-012.

Verification
REQ-030 DEBOUNCE_CYCLES=4; btn=7'h05 held 10 cycles -> btn_state=7'h05; 2-cycle glitch on btn[1] -> btn_state unchanged.
REQ-031 btn_state=7'h2A; latch pulse, then 8 ctrl_clk edges (4-cycle phases) -> ctrl_data bits 0,1,0,1,0,1,0,1, then 0, one frame_done pulse.
REQ-032 Latch reasserted after 3 clk edges -> frame restarts from bit 0 with current btn_state; no frame_done.
REQ-033 9th and 10th ctrl_clk edges after a frame -> ctrl_data stays 0, no second frame_done.
REQ-034 reset_n pulsed low after 4 shifted bits -> ctrl_data 0 at once; subsequent ctrl_clk edges ignored until next latch.
REQ-035 ctrl_clk edge coincident with latch high -> ignored; first bit after latch falls is btn_state[0].
